// File: rtl/picobello_uart_pkg.sv
// Shared types and constants for the picobello UART receiver.
// PICOBELLO_UART_RX_PARITY_EN adds the PARITY state to the FSM encoding.
package picobello_uart_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned MinDiv    = 4;
  localparam int unsigned IdxWidth  = $clog2(DataWidth);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PICOBELLO_UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/picobello_uart_rx_fifo.sv
// Receive FIFO: extra pointer bit separates full from empty; a push while full
// is accepted only when a pop frees the head slot in the same cycle.
module picobello_uart_rx_fifo
  import picobello_uart_pkg::*;
#(
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 full_o,
  input  logic                 pop_i,
  output logic                 empty_o,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned PtrWidth = $clog2(FifoDepth);

  logic [PtrWidth:0]    wptr_q, wptr_d;
  logic [PtrWidth:0]    rptr_q, rptr_d;
  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [DataWidth-1:0] mem_d [FifoDepth];
  logic                 do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrWidth] != rptr_q[PtrWidth]) &&
                   (wptr_q[PtrWidth-1:0] == rptr_q[PtrWidth-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[PtrWidth-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (do_push) begin
      mem_d[wptr_q[PtrWidth-1:0]] = wdata_i;
      wptr_d = wptr_q + (PtrWidth+1)'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + (PtrWidth+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: rdata_o is masked while empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/picobello_uart_rx.sv
// UART receiver (8 data bits, 1 stop, optional parity) with a receive FIFO.
// Define PICOBELLO_UART_RX_PARITY_EN to build in parity reception and checking.
module picobello_uart_rx
  import picobello_uart_pkg::*;
#(
  parameter int unsigned DivWidth  = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  output logic [7:0]          data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                overflow_o,
  output logic                busy_o
);

  rx_state_e             state_q, state_d;
  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_sync_q, rx_sync_d;
  logic                  rx_prev_q, rx_prev_d;
  logic [DivWidth-1:0]   cnt_q, cnt_d;
  logic [DivWidth-1:0]   div_q, div_d;
  logic [IdxWidth-1:0]   bit_idx_q, bit_idx_d;
  logic [DataWidth-1:0]  shift_q, shift_d;
  logic                  bad_q, bad_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;
  logic                  busy_q, busy_d;

  logic                  fall_c, expire_c, push_c, pop_c;
  logic                  fifo_full, fifo_empty;
  logic [DivWidth-1:0]   div_eff_c;

`ifdef PICOBELLO_UART_RX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  parity_err_q, parity_err_d;
`else
  logic                  unused_parity_c;
  assign unused_parity_c = parity_en_i ^ parity_odd_i;
`endif

  assign fall_c    = rx_prev_q && !rx_sync_q;
  assign expire_c  = (cnt_q == DivWidth'(1));
  assign div_eff_c = (div_i < DivWidth'(MinDiv)) ? DivWidth'(MinDiv) : div_i;
  assign pop_c     = valid_o && ready_i;

  // Next-state, datapath and registered pulse computation.
  always_comb begin
    state_d     = state_q;
    rx_meta_d   = rx_i;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    bad_d       = bad_q;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    push_c      = 1'b0;
`ifdef PICOBELLO_UART_RX_PARITY_EN
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    parity_err_d = 1'b0;
`endif

    if (state_q != IDLE) begin
      cnt_d = cnt_q - DivWidth'(1);
    end

    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d   = START;
          div_d     = div_eff_c;
          cnt_d     = div_eff_c >> 1;
          bit_idx_d = '0;
          bad_d     = 1'b0;
`ifdef PICOBELLO_UART_RX_PARITY_EN
          par_en_d  = parity_en_i;
          par_odd_d = parity_odd_i;
`endif
        end
      end
      START: begin
        if (expire_c) begin
          cnt_d   = div_q;
          state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (expire_c) begin
          cnt_d     = div_q;
          shift_d   = {rx_sync_q, shift_q[DataWidth-1:1]};
          bit_idx_d = bit_idx_q + IdxWidth'(1);
          if (bit_idx_q == IdxWidth'(DataWidth - 1)) begin
`ifdef PICOBELLO_UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef PICOBELLO_UART_RX_PARITY_EN
      PARITY: begin
        if (expire_c) begin
          cnt_d   = div_q;
          state_d = STOP;
          if (rx_sync_q != ((^shift_q) ^ par_odd_q)) begin
            parity_err_d = 1'b1;
            bad_d        = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (expire_c) begin
          state_d = IDLE;
          if (!rx_sync_q) begin
            frame_err_d = 1'b1;
          end else if (!bad_q) begin
            push_c     = 1'b1;
            overflow_d = fifo_full && !pop_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      bad_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PICOBELLO_UART_RX_PARITY_EN
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      bad_q       <= bad_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
`ifdef PICOBELLO_UART_RX_PARITY_EN
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  picobello_uart_rx_fifo #(
    .FifoDepth(FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_c),
    .wdata_i(shift_q),
    .full_o (fifo_full),
    .pop_i  (ready_i),
    .empty_o(fifo_empty),
    .rdata_o(data_o)
  );

  assign valid_o     = !fifo_empty;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = busy_q;
`ifdef PICOBELLO_UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_picobello_uart_rx.sv
// Directed bench for picobello_uart_rx; parity scenario depends on PICOBELLO_UART_RX_PARITY_EN.
module tb_picobello_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_i;
  logic [15:0] div_i;
  logic        parity_en_i;
  logic        parity_odd_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        frame_err_o;
  logic        parity_err_o;
  logic        overflow_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int ov_cnt   = 0;

  always #5 clk_i = ~clk_i;

  picobello_uart_rx #(
    .DivWidth (16),
    .FifoDepth(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .div_i       (div_i),
    .parity_en_i (parity_en_i),
    .parity_odd_i(parity_odd_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (frame_err_o)  fe_cnt++;
    if (parity_err_o) pe_cnt++;
    if (overflow_o)   ov_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic with_par, input logic par_bit, input int per);
    rx_i = 1'b0;
    idle(per);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      idle(per);
    end
    if (with_par) begin
      rx_i = par_bit;
      idle(per);
    end
    rx_i = stop_bit;
    idle(per);
    rx_i = 1'b1;
    idle(4);
  endtask

  task automatic wait_valid(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_one();
    ready_i = 1'b1;
    idle(1);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle(3);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if ({frame_err_o, parity_err_o, overflow_o} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got=%b exp=000", {frame_err_o, parity_err_o, overflow_o});
    end
    rst_i = 1'b0;
    idle(4);
  endtask

  task automatic test_basic();
    logic found;
    int fe0 = fe_cnt, pe0 = pe_cnt, ov0 = ov_cnt;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 16);
      wait_valid(9*16 + 8 + 3, found);
    join
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", found); end
    checks++; if (data_o !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", data_o); end
    idle(5);
    checks++; if (data_o !== 8'hA5 || valid_o !== 1'b1) begin
      failures++; $display("FAIL basic_hold got=%h/%b exp=a5/1", data_o, valid_o);
    end
    checks++; if ((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0) !== 0) begin
      failures++; $display("FAIL basic_no_err got=%0d exp=0", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0));
    end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy_o); end
    pop_one();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL basic_pop got=%b exp=0", valid_o); end
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt, pe0 = pe_cnt;
    rx_i = 1'b0;
    idle(3);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL glitch_start got=%b exp=1", busy_o); end
    idle(2);
    rx_i = 1'b1;
    idle(30);
    checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++; $display("FAIL glitch_abort got busy=%b valid=%b exp=0/0", busy_o, valid_o);
    end
    checks++; if ((fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin
      failures++; $display("FAIL glitch_err got=%0d exp=0", (fe_cnt - fe0) + (pe_cnt - pe0));
    end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16);
    idle(4);
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL frame_err_pulse got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL frame_err_drop got=%b exp=0", valid_o); end
  endtask

  task automatic test_parity();
    int pe0 = pe_cnt;
    parity_en_i  = 1'b1;
    parity_odd_i = 1'b0;
`ifdef PICOBELLO_UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 16);
    checks++; if (pe_cnt - pe0 !== 1) begin failures++; $display("FAIL parity_bad_pulse got=%0d exp=1", pe_cnt - pe0); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL parity_bad_drop got=%b exp=0", valid_o); end
    pe0 = pe_cnt;
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 16);
`else
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 16);
`endif
    checks++; if (valid_o !== 1'b1 || data_o !== 8'h01) begin
      failures++; $display("FAIL parity_good got=%h/%b exp=01/1", data_o, valid_o);
    end
    checks++; if (pe_cnt - pe0 !== 0) begin failures++; $display("FAIL parity_good_err got=%0d exp=0", pe_cnt - pe0); end
    pop_one();
    parity_en_i = 1'b0;
  endtask

  task automatic test_div_change();
    fork
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 16);
      begin idle(40); div_i = 16'd7; end
    join
    checks++; if (valid_o !== 1'b1 || data_o !== 8'h5A) begin
      failures++; $display("FAIL div_change got=%h/%b exp=5a/1", data_o, valid_o);
    end
    div_i = 16'd16;
    pop_one();
  endtask

  task automatic test_min_div();
    div_i = 16'd2;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 4);
    checks++; if (valid_o !== 1'b1 || data_o !== 8'hC3) begin
      failures++; $display("FAIL min_div got=%h/%b exp=c3/1", data_o, valid_o);
    end
    div_i = 16'd16;
    pop_one();
  endtask

  task automatic test_overflow();
    int ov0 = ov_cnt;
    for (int k = 0; k < 5; k++) begin
      send_frame(8'(8'h10 + k), 1'b1, 1'b0, 1'b0, 16);
      if (k == 3) begin
        checks++; if (ov_cnt - ov0 !== 0) begin failures++; $display("FAIL overflow_early got=%0d exp=0", ov_cnt - ov0); end
      end
    end
    checks++; if (ov_cnt - ov0 !== 1) begin failures++; $display("FAIL overflow_pulse got=%0d exp=1", ov_cnt - ov0); end
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (valid_o !== 1'b1 || data_o !== 8'(8'h10 + k)) begin
        failures++; $display("FAIL drain_%0d got=%h/%b exp=%h/1", k, data_o, valid_o, 8'(8'h10 + k));
      end
      idle(1);
    end
    ready_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", valid_o); end
  endtask

  task automatic test_reset_mid_frame();
    logic found;
    int fe0;
    send_frame(8'h21, 1'b1, 1'b0, 1'b0, 16);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 16);
    checks++; if (valid_o !== 1'b1 || data_o !== 8'h21) begin
      failures++; $display("FAIL queued_head got=%h/%b exp=21/1", data_o, valid_o);
    end
    fe0 = fe_cnt;
    fork
      send_frame(8'hF8, 1'b1, 1'b0, 1'b0, 16);
      begin
        idle(72);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy_o); end
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
          failures++; $display("FAIL mid_reset got valid=%b busy=%b exp=0/0", valid_o, busy_o);
        end
      end
    join
    checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || fe_cnt != fe0) begin
      failures++; $display("FAIL mid_rearm got valid=%b busy=%b fe=%0d exp=0/0/0", valid_o, busy_o, fe_cnt - fe0);
    end
    fork
      send_frame(8'h55, 1'b1, 1'b0, 1'b0, 16);
      wait_valid(9*16 + 8 + 3, found);
    join
    checks++; if (found !== 1'b1 || data_o !== 8'h55) begin
      failures++; $display("FAIL after_reset got=%h/%b exp=55/1", data_o, found);
    end
    pop_one();
  endtask

  initial begin
    rst_i        = 1'b1;
    rx_i         = 1'b1;
    div_i        = 16'd16;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    ready_i      = 1'b0;
    idle(1);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_div_change();
    test_min_div();
    test_overflow();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
